// File: rtl/simmem_req_bridge.sv
// Valid/ready request bridge onto the flat per-cycle SimMem model, one independent FSM per channel.
// Optional feature macro: SIMMEM_MISALIGN_CHECK_EN (misaligned requests answer resp_err without touching the model).

module simmem_req_chan #(
    parameter int XLEN  = 64,
    parameter int LAT   = 1,
    parameter int LAT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [1:0]      i_req_size,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] o_resp_data,
    output logic            o_resp_err,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_type,
    input  logic [XLEN-1:0] i_mem_rdata
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]      r_state;
    logic [LAT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_data;
    logic [1:0]      r_size;
    logic            r_err;

    logic            w_accept;
    logic            w_misalign;
    logic            w_issue;

    assign w_accept = i_req_valid && (r_state == S_IDLE);

`ifdef SIMMEM_MISALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        case (i_req_size)
            2'd1:    w_misalign = i_req_addr[0];
            2'd2:    w_misalign = |i_req_addr[1:0];
            2'd3:    w_misalign = |i_req_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_size  <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr <= i_req_addr;
                        r_size <= i_req_size;
                        r_err  <= w_misalign;
                        r_cnt  <= LAT_W'(LAT);
                        if (w_misalign)
                            r_state <= S_CAPT;
                        else if (LAT == 0)
                            r_state <= S_ISSUE;
                        else
                            r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // cnt==1 here means it reaches 0 on this edge
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt <= LAT_W'(1))
                        r_state <= S_ISSUE;
                end
                S_ISSUE: r_state <= S_CAPT;
                S_CAPT: begin
                    r_data  <= r_err ? '0 : i_mem_rdata;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (i_resp_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Reset kills the model drive in the same cycle, not just at the next edge
    assign w_issue      = rst_n && (r_state == S_ISSUE);
    assign o_mem_addr   = w_issue ? r_addr : '0;
    assign o_mem_type   = w_issue ? XLEN'({1'b0, r_size} + 3'd1) : '0;
    assign o_req_ready  = (r_state == S_IDLE);
    assign o_resp_valid = (r_state == S_RESP);
    assign o_resp_data  = o_resp_valid ? r_data : '0;
    assign o_resp_err   = o_resp_valid && r_err;
endmodule

module simmem_req_bridge #(
    parameter int XLEN  = 64,
    parameter int ILAT  = 1,
    parameter int DLAT  = 2,
    parameter int LAT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req_valid,
    output logic            i_req_ready,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [1:0]      i_req_size,
    output logic            i_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] i_resp_data,
    output logic            i_resp_err,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic [1:0]      d_req_size,
    input  logic            d_req_wen,
    input  logic [XLEN-1:0] d_req_wdata,
    output logic            d_resp_valid,
    input  logic            d_resp_ready,
    output logic [XLEN-1:0] d_resp_data,
    output logic            d_resp_err,
    output logic [XLEN-1:0] mem_iaddr,
    output logic [XLEN-1:0] mem_itype,
    input  logic [XLEN-1:0] mem_idata,
    output logic [XLEN-1:0] mem_daddr,
    output logic [XLEN-1:0] mem_dtype,
    output logic [XLEN-1:0] mem_dwdata,
    output logic            mem_dwen,
    input  logic [XLEN-1:0] mem_drdata
);
    logic            r_d_wen;
    logic [XLEN-1:0] r_d_wdata;
    logic            w_d_issue;
    logic [XLEN-1:0] w_d_rdata;

    simmem_req_chan #(.XLEN(XLEN), .LAT(ILAT), .LAT_W(LAT_W)) u_ichan (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (i_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_size   (i_req_size),
        .o_resp_valid (i_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_resp_data  (i_resp_data),
        .o_resp_err   (i_resp_err),
        .o_mem_addr   (mem_iaddr),
        .o_mem_type   (mem_itype),
        .i_mem_rdata  (mem_idata)
    );

    // Store payload lives here so the shared channel FSM stays read-only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d_wen   <= 1'b0;
            r_d_wdata <= '0;
        end else if (d_req_valid && d_req_ready) begin
            r_d_wen   <= d_req_wen;
            r_d_wdata <= d_req_wdata;
        end
    end

    assign w_d_rdata = r_d_wen ? '0 : mem_drdata;

    simmem_req_chan #(.XLEN(XLEN), .LAT(DLAT), .LAT_W(LAT_W)) u_dchan (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (d_req_valid),
        .o_req_ready  (d_req_ready),
        .i_req_addr   (d_req_addr),
        .i_req_size   (d_req_size),
        .o_resp_valid (d_resp_valid),
        .i_resp_ready (d_resp_ready),
        .o_resp_data  (d_resp_data),
        .o_resp_err   (d_resp_err),
        .o_mem_addr   (mem_daddr),
        .o_mem_type   (mem_dtype),
        .i_mem_rdata  (w_d_rdata)
    );

    // A non-zero type is exactly the issue cycle, already gated by reset
    assign w_d_issue  = (mem_dtype != '0);
    assign mem_dwen   = w_d_issue && r_d_wen;
    assign mem_dwdata = w_d_issue ? r_d_wdata : '0;
endmodule

// File: tb/tb_simmem_req_bridge.sv
// Bench for simmem_req_bridge: SimMem stand-in, directed table, corner sequences and randomized traffic
// checked against a transaction-level memory model.

module tb_simmem_req_bridge;
    localparam int XLEN = 64;
    localparam int ILAT = 1;
    localparam int DLAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic i_req_valid, i_req_ready, i_resp_valid, i_resp_ready, i_resp_err;
    logic [1:0] i_req_size;
    logic [63:0] i_req_addr, i_resp_data;
    logic d_req_valid, d_req_ready, d_req_wen, d_resp_valid, d_resp_ready, d_resp_err;
    logic [1:0] d_req_size;
    logic [63:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [63:0] mem_iaddr, mem_itype, mem_idata, mem_daddr, mem_dtype, mem_dwdata, mem_drdata;
    logic mem_dwen;

    always #5 clk = ~clk;

    simmem_req_bridge #(.XLEN(XLEN), .ILAT(ILAT), .DLAT(DLAT), .LAT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_req_size(i_req_size), .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
        .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_size(d_req_size), .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data),
        .d_resp_err(d_resp_err),
        .mem_iaddr(mem_iaddr), .mem_itype(mem_itype), .mem_idata(mem_idata),
        .mem_daddr(mem_daddr), .mem_dtype(mem_dtype), .mem_dwdata(mem_dwdata),
        .mem_dwen(mem_dwen), .mem_drdata(mem_drdata)
    );

    function automatic logic [63:0] init_word(input int k);
        return {16'hC0DE, 16'(k), 32'h1234_5678 ^ (32'(k) * 32'h9E37_79B9)};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input int off, input int n);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++)
            if (b >= off && b < off + n) m[b*8 +: 8] = 8'hFF;
        return (old & ~m) | (wd & m);
    endfunction

    // SimMem stand-in: accesses happen on the edge that closes the issue cycle
    logic [63:0] sim_mem [0:1023];
    logic sim_init_done;
    always @(posedge clk) begin
        if (sim_init_done !== 1'b1) begin
            for (int k = 0; k < 1024; k++) sim_mem[k] <= init_word(k);
            sim_init_done <= 1'b1;
        end else begin
            if (mem_itype != 0) mem_idata <= sim_mem[mem_iaddr[12:3]];
            if (mem_dtype != 0) begin
                if (mem_dwen)
                    sim_mem[mem_daddr[12:3]] <= merge(sim_mem[mem_daddr[12:3]], mem_dwdata,
                        int'(mem_daddr[2:0]), 1 << (int'(mem_dtype[2:0]) - 1));
                else
                    mem_drdata <= sim_mem[mem_daddr[12:3]];
            end
        end
    end

    int i_acc_cnt = 0, d_acc_cnt = 0, dwen_cnt = 0, both_cnt = 0;
    logic [63:0] last_itype = '0, last_dtype = '0;
    always @(posedge clk) begin
        if (mem_itype != 0) begin i_acc_cnt <= i_acc_cnt + 1; last_itype <= mem_itype; end
        if (mem_dtype != 0) begin d_acc_cnt <= d_acc_cnt + 1; last_dtype <= mem_dtype; end
        if (mem_dwen) dwen_cnt <= dwen_cnt + 1;
        if (mem_itype != 0 && mem_dtype != 0) both_cnt <= both_cnt + 1;
    end

    int n_pass = 0, n_total = 0;
    logic [63:0] ref_mem [0:1023];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic d_txn(input logic [63:0] addr, input logic [1:0] size, input logic wen,
                         input logic [63:0] wdata, input int hold,
                         output logic [63:0] data, output logic err, output int lat);
        int guard, bad, acc0;
        @(negedge clk);
        guard = 0;
        while (!d_req_ready && guard < 50) begin @(negedge clk); guard++; end
        d_req_valid = 1'b1; d_req_addr = addr; d_req_size = size; d_req_wen = wen; d_req_wdata = wdata;
        @(negedge clk);
        d_req_valid = 1'b0; d_req_addr = {$urandom, $urandom}; d_req_wdata = {$urandom, $urandom};
        d_req_size = 2'($urandom); d_req_wen = 1'($urandom);
        lat = 1;
        while (!d_resp_valid && lat < 60) begin @(negedge clk); lat++; end
        if (!d_resp_valid) check("d_resp_timeout", 64'(d_resp_valid), 64'd1);
        data = d_resp_data; err = d_resp_err; acc0 = d_acc_cnt; bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!(d_resp_valid && d_resp_data === data && d_resp_err === err &&
                  !d_req_ready && d_acc_cnt == acc0)) bad++;
        end
        if (hold > 0) check("d_hold_stable", 64'(bad), 64'd0);
        d_resp_ready = 1'b1;
        @(negedge clk);
        d_resp_ready = 1'b0;
        check("d_back_idle", {62'd0, d_resp_valid, d_req_ready}, 64'd1);
        $display("D %s addr=%h size=%0d wdata=%h data=%h err=%0d lat=%0d hold=%0d",
                 wen ? "ST" : "LD", addr, size, wdata, data, err, lat, hold);
    endtask

    task automatic i_txn(input logic [63:0] addr, input logic [1:0] size, input int hold,
                         output logic [63:0] data, output logic err, output int lat);
        int guard, bad, acc0;
        @(negedge clk);
        guard = 0;
        while (!i_req_ready && guard < 50) begin @(negedge clk); guard++; end
        i_req_valid = 1'b1; i_req_addr = addr; i_req_size = size;
        @(negedge clk);
        i_req_valid = 1'b0; i_req_addr = {$urandom, $urandom}; i_req_size = 2'($urandom);
        lat = 1;
        while (!i_resp_valid && lat < 60) begin @(negedge clk); lat++; end
        if (!i_resp_valid) check("i_resp_timeout", 64'(i_resp_valid), 64'd1);
        data = i_resp_data; err = i_resp_err; acc0 = i_acc_cnt; bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!(i_resp_valid && i_resp_data === data && !i_req_ready && i_acc_cnt == acc0)) bad++;
        end
        if (hold > 0) check("i_hold_stable", 64'(bad), 64'd0);
        i_resp_ready = 1'b1;
        @(negedge clk);
        i_resp_ready = 1'b0;
        check("i_back_idle", {62'd0, i_resp_valid, i_req_ready}, 64'd1);
        $display("I FE addr=%h size=%0d data=%h err=%0d lat=%0d hold=%0d", addr, size, data, err, lat, hold);
    endtask

    typedef struct {
        bit          is_d;
        bit          wen;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t vecs[8];
        logic [63:0] data, data2;
        logic err, err2;
        int lat, lat2, acc0, dw0, b0, guard;

        for (int k = 0; k < 1024; k++) ref_mem[k] = init_word(k);
        vecs[0] = '{0, 0, 64'h8000_0000, 2'd2, 64'd0, init_word(0), ILAT + 3};
        vecs[1] = '{0, 0, 64'h8000_0040, 2'd3, 64'd0, init_word(8), ILAT + 3};
        vecs[2] = '{1, 1, 64'h8000_1000, 2'd3, 64'hDEADBEEF_CAFEF00D, 64'd0, DLAT + 3};
        vecs[3] = '{1, 0, 64'h8000_1000, 2'd3, 64'd0, 64'hDEADBEEF_CAFEF00D, DLAT + 3};
        vecs[4] = '{1, 1, 64'h8000_1008, 2'd1, 64'hFFFF_FFFF_FFFF_1234, 64'd0, DLAT + 3};
        vecs[5] = '{1, 0, 64'h8000_1008, 2'd3, 64'd0, (init_word(513) & ~64'hFFFF) | 64'h1234, DLAT + 3};
        vecs[6] = '{1, 1, 64'h8000_1011, 2'd0, 64'h1111_1111_1111_AB11, 64'd0, DLAT + 3};
        vecs[7] = '{1, 0, 64'h8000_1010, 2'd2, 64'd0, (init_word(514) & ~64'hFF00) | 64'hAB00, DLAT + 3};

        rst_n = 1'b0;
        i_req_valid = 0; i_req_addr = 0; i_req_size = 0; i_resp_ready = 0;
        d_req_valid = 0; d_req_addr = 0; d_req_size = 0; d_req_wen = 0; d_req_wdata = 0; d_resp_ready = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_itype", mem_itype, 64'd0);
        check("rst_mem_dtype", mem_dtype, 64'd0);
        check("rst_mem_addr", mem_iaddr | mem_daddr | mem_dwdata, 64'd0);
        check("rst_mem_dwen", 64'(mem_dwen), 64'd0);
        check("rst_resp_valid", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
        check("rst_req_ready", {62'd0, i_req_ready, d_req_ready}, 64'd3);
        rst_n = 1'b1;

        // Directed table
        for (int v = 0; v < 8; v++) begin
            acc0 = vecs[v].is_d ? d_acc_cnt : i_acc_cnt;
            dw0 = dwen_cnt;
            if (vecs[v].is_d)
                d_txn(vecs[v].addr, vecs[v].size, vecs[v].wen, vecs[v].wdata, v % 3, data, err, lat);
            else
                i_txn(vecs[v].addr, vecs[v].size, v % 3, data, err, lat);
            check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
            check($sformatf("vec%0d_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
            check($sformatf("vec%0d_err", v), 64'(err), 64'd0);
            check($sformatf("vec%0d_accesses", v),
                  64'((vecs[v].is_d ? d_acc_cnt : i_acc_cnt) - acc0), 64'd1);
            check($sformatf("vec%0d_dwen_pulses", v), 64'(dwen_cnt - dw0), 64'(vecs[v].wen));
            check($sformatf("vec%0d_type", v), vecs[v].is_d ? last_dtype : last_itype,
                  64'(vecs[v].size) + 64'd1);
            if (vecs[v].wen)
                ref_mem[vecs[v].addr[12:3]] = merge(ref_mem[vecs[v].addr[12:3]], vecs[v].wdata,
                    int'(vecs[v].addr[2:0]), 1 << vecs[v].size);
        end

        // Backpressure: 10 cycles of d_resp_ready=0
        d_txn(64'h8000_1000, 2'd3, 1'b0, 64'd0, 10, data, err, lat);
        check("bp_data", data, ref_mem[512]);

        // Concurrent: D accepted one edge before I so both issue together
        b0 = both_cnt;
        @(negedge clk);
        d_req_valid = 1; d_req_addr = 64'h8000_1040; d_req_size = 2'd3; d_req_wen = 0;
        @(negedge clk);
        d_req_valid = 0; i_req_valid = 1; i_req_addr = 64'h8000_0080; i_req_size = 2'd3;
        @(negedge clk);
        i_req_valid = 0;
        guard = 0;
        while (!(i_resp_valid && d_resp_valid) && guard < 30) begin @(negedge clk); guard++; end
        check("conc_both_resp", {62'd0, i_resp_valid, d_resp_valid}, 64'd3);
        check("conc_same_issue", 64'(both_cnt - b0), 64'd1);
        check("conc_i_data", i_resp_data, init_word(16));
        check("conc_d_data", d_resp_data, ref_mem[520]);
        i_resp_ready = 1; d_resp_ready = 1;
        @(negedge clk);
        i_resp_ready = 0; d_resp_ready = 0;
        $display("C I+D concurrent fetch/load done");

        // Reset while a store waits: it must never be written
        d_req_valid = 1; d_req_addr = 64'h8000_1048; d_req_size = 2'd3; d_req_wen = 1;
        d_req_wdata = 64'h1111_2222_3333_4444;
        i_req_valid = 1; i_req_addr = 64'h8000_0088; i_req_size = 2'd3;
        @(negedge clk);
        d_req_valid = 0; i_req_valid = 0; dw0 = dwen_cnt; rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        check("wait_rst_no_dwen", 64'(dwen_cnt - dw0), 64'd0);
        check("wait_rst_ready", {62'd0, i_req_ready, d_req_ready}, 64'd3);
        check("wait_rst_resp", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
        $display("R reset during store WAIT");
        d_txn(64'h8000_1048, 2'd3, 1'b0, 64'd0, 0, data, err, lat);
        check("wait_rst_mem_intact", data, ref_mem[521]);

        // Reset during ISSUE overrides the store drive immediately
        @(negedge clk);
        d_req_valid = 1; d_req_addr = 64'h8000_1050; d_req_size = 2'd3; d_req_wen = 1;
        d_req_wdata = 64'h5555_6666_7777_8888;
        @(negedge clk);
        d_req_valid = 0; dw0 = dwen_cnt;
        repeat (2) @(negedge clk);
        check("issue_dwen_high", 64'(mem_dwen), 64'd1);
        rst_n = 0;
        #1;
        check("issue_rst_dwen", 64'(mem_dwen), 64'd0);
        check("issue_rst_dtype", mem_dtype, 64'd0);
        @(negedge clk);
        rst_n = 1;
        check("issue_rst_no_write", 64'(dwen_cnt - dw0), 64'd0);
        $display("R reset during store ISSUE");
        d_txn(64'h8000_1050, 2'd3, 1'b0, 64'd0, 0, data, err, lat);
        check("issue_rst_mem_intact", data, ref_mem[522]);

        // Misaligned load
        acc0 = d_acc_cnt;
        d_txn(64'h8000_0003, 2'd2, 1'b0, 64'd0, 1, data, err, lat);
`ifdef SIMMEM_MISALIGN_CHECK_EN
        check("mis_err", 64'(err), 64'd1);
        check("mis_data", data, 64'd0);
        check("mis_lat", 64'(lat), 64'd2);
        check("mis_no_access", 64'(d_acc_cnt - acc0), 64'd0);
`else
        check("mis_err", 64'(err), 64'd0);
        check("mis_data", data, init_word(0));
        check("mis_lat", 64'(lat), 64'(DLAT + 3));
        check("mis_access", 64'(d_acc_cnt - acc0), 64'd1);
`endif

        // Randomized traffic on both channels against the memory model
        fork
            begin
                for (int t = 0; t < 30; t++) begin
                    int idx, n, off, hold;
                    logic [1:0] sz;
                    logic wen;
                    logic [63:0] wd, a, rd, exp;
                    logic re;
                    int rl;
                    idx = 512 + $urandom_range(0, 31);
                    sz = 2'($urandom_range(0, 3));
                    n = 1 << sz;
                    off = $urandom_range(0, (8 / n) - 1) * n;
                    a = 64'h8000_0000 + 64'(idx * 8 + off);
                    wen = 1'($urandom_range(0, 1));
                    wd = {$urandom, $urandom};
                    hold = $urandom_range(0, 3);
                    exp = wen ? 64'd0 : ref_mem[idx];
                    d_txn(a, sz, wen, wd, hold, rd, re, rl);
                    if (wen) ref_mem[idx] = merge(ref_mem[idx], wd, off, n);
                    check("rnd_d_data", rd, exp);
                    check("rnd_d_lat", 64'(rl), 64'(DLAT + 3));
                end
            end
            begin
                for (int t = 0; t < 30; t++) begin
                    int idx, n, off, hold;
                    logic [1:0] sz;
                    logic [63:0] a, rd;
                    logic re;
                    int rl;
                    idx = $urandom_range(0, 127);
                    sz = 2'($urandom_range(0, 3));
                    n = 1 << sz;
                    off = $urandom_range(0, (8 / n) - 1) * n;
                    a = 64'h8000_0000 + 64'(idx * 8 + off);
                    hold = $urandom_range(0, 3);
                    i_txn(a, sz, hold, rd, re, rl);
                    check("rnd_i_data", rd, init_word(idx));
                    check("rnd_i_lat", 64'(rl), 64'(ILAT + 3));
                end
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
